fetch_seq32: RTL
================

// Module: fetch_seq32
// PURPOSE
//  Instruction-fetch sequencer that feeds the instruction decoder. Owns the PC,
//  issues one request at a time to instruction memory, and holds the fetched
//  word in a single output register until the decoder accepts it. Takes branch
//  redirects (take/offset/link) from the decode stage, squashes wrong-path
//  fetches, and raises the r14 link write.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded on reset
//  PIPE_OFFSET  32'd8          PC-read offset added to br_pc when forming a branch target
//  CNT_W        16             width of squash counter (saturating)
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  rst          in   1      synchronous, active-high reset
//  en           in   1      run enable; 0 = stop issuing new fetches
//  imem_req     out  1      fetch request; held high until imem_ack
//  imem_addr    out  32     fetch byte address, word aligned; stable while imem_req=1
//  imem_ack     in   1      1-cycle pulse: imem_rdata valid, request complete
//  imem_rdata   in   32     fetched instruction word
//  instr_out    out  32     instruction to decoder
//  instr_pc     out  32     address of instr_out
//  instr_valid  out  1      instr_out/instr_pc valid
//  dec_ready    in   1      decoder accepts instr_out this cycle
//  br_take      in   1      1-cycle pulse: branch taken at decode
//  br_pc        in   32     address of the branch instruction
//  br_off       in   32     sign-extended byte offset (already <<2)
//  br_link      in   1      branch-with-link; qualified by br_take
//  link_we      out  1      1-cycle pulse: write link_val to r14
//  link_val     out  32     return address = br_pc + 4
//  squash_cnt   out  CNT_W  number of fetches discarded by redirects, saturating
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0,
//   instr_out=0, instr_pc=0, link_we=0, link_val=0, squash_cnt=0. Reset dominates all inputs.
//  Handshake: accept = instr_valid & dec_ready & ~br_take. Decoder never consumes in a br_take cycle.
//  States:
//   IDLE : imem_req=0. en=1 -> REQ (imem_req=1, imem_addr=pc starting next cycle).
//   REQ  : imem_req=1, imem_addr=pc. On imem_ack: instr_out<=imem_rdata, instr_pc<=pc,
//          instr_valid<=1, pc<=pc+4, -> HOLD. No ack: stay.
//   HOLD : instr_valid=1, imem_req=0. On accept: instr_valid<=0; -> REQ if en else IDLE.
//   DRAIN: imem_req=1 on old addr until imem_ack; returned data dropped, squash_cnt++;
//          then -> REQ at the redirected pc (even if en=0; completes redirect fetch once).
//  Redirect (br_take=1, highest priority, any state):
//   target = (br_pc + PIPE_OFFSET + br_off) mod 2^32, bits[1:0] forced to 00; pc<=target.
//   instr_valid<=0 next cycle. If HOLD with a valid word: squash_cnt++.
//   IDLE -> IDLE (pc updated only). HOLD -> REQ. REQ without ack -> DRAIN.
//   REQ with imem_ack same cycle -> data dropped, squash_cnt++, -> REQ at target.
//   DRAIN + br_take -> stay DRAIN, target overwritten (latest wins).
//   br_link=1: link_we=1 and link_val=br_pc+4 in the following cycle; else link_we=0.
//  Latency: redirect to imem_req at target = 1 cycle (from IDLE/HOLD); ack to instr_valid = 1 cycle.
//  PC arithmetic is 32-bit wrapping; 32'hFFFF_FFFC + 4 -> 0.
//  en=0 never aborts an outstanding request; REQ completes to HOLD, then IDLE after accept.
//  squash_cnt saturates at all-ones; never wraps.
//  imem_ack outside REQ/DRAIN is ignored.
// TESTING
//  1 rst, en=1, ack 2 cycles after each req, dec_ready=1 -> instr_pc 0,4,8,12 in order; imem_addr stable while req.
//  2 HOLD with dec_ready=0 for 5 cycles -> instr_valid held, no imem_req; dec_ready=1 -> next req addr = instr_pc+4.
//  3 br_take br_pc=0x100 br_off=0xFFFF_FFF0 br_link=1 in HOLD -> next req addr 0xF8,
//    link_we pulse with link_val 0x104, squash_cnt=1.
//  4 br_take in REQ, ack 3 cycles later -> DRAIN, old word never asserts instr_valid, then req at target.
//  5 br_take coincident with imem_ack, then second br_take during DRAIN -> only the second target is fetched.
//  6 rst asserted mid-REQ and in DRAIN -> next cycle all outputs at reset values; squash_cnt forced to 0xFFFF holds.

Source files
------------

// File: rtl/fetch_seq32.sv
// Instruction-fetch sequencer: owns the PC, issues one instruction-memory request at a
// time, buffers the fetched word for the decoder and handles branch redirects and links.
module fetch_seq32 #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] PIPE_OFFSET = 32'd8,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr_out,
  output logic [31:0]      instr_pc,
  output logic             instr_valid,
  input  logic             dec_ready,
  input  logic             br_take,
  input  logic [31:0]      br_pc,
  input  logic [31:0]      br_off,
  input  logic             br_link,
  output logic             link_we,
  output logic [31:0]      link_val,
  output logic [CNT_W-1:0] squash_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        instr_out_q, instr_out_d;
  logic [31:0]        instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic               link_we_q, link_we_d;
  logic [31:0]        link_val_q, link_val_d;
  logic [CNT_W-1:0]   squash_cnt_q, squash_cnt_d;

  logic [31:0]        target_sum;
  logic [31:0]        target;
  logic               accept;
  logic               squash_inc;

  assign target_sum = br_pc + PIPE_OFFSET + br_off;
  assign target     = {target_sum[31:2], 2'b00};
  assign accept     = instr_valid_q & dec_ready & ~br_take;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    squash_inc    = 1'b0;
    link_we_d     = br_take & br_link;
    link_val_d    = (br_take && br_link) ? br_pc + 32'd4 : link_val_q;

    unique case (state_q)
      S_IDLE: begin
        if (br_take)  pc_d    = target;
        else if (en)  state_d = S_REQ;
      end
      S_REQ: begin
        if (br_take) begin
          // A word returning in the redirect cycle is wrong-path; refetch at the target.
          pc_d       = target;
          squash_inc = imem_ack;
          state_d    = imem_ack ? S_REQ : S_DRAIN;
        end else if (imem_ack) begin
          instr_out_d   = imem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + 32'd4;
          state_d       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (br_take) begin
          pc_d          = target;
          instr_valid_d = 1'b0;
          squash_inc    = instr_valid_q;
          state_d       = S_REQ;
        end else if (accept) begin
          instr_valid_d = 1'b0;
          state_d       = en ? S_REQ : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (br_take) pc_d = target;
        if (imem_ack) begin
          squash_inc = 1'b1;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    squash_cnt_d = (squash_inc && (squash_cnt_q != '1)) ? squash_cnt_q + CNT_W'(1) : squash_cnt_q;
    // The outstanding request keeps its old address while draining, even though pc already moved.
    addr_d = (state_d == S_DRAIN) ? addr_q : pc_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      addr_q        <= RESET_PC;
      instr_out_q   <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      link_we_q     <= 1'b0;
      link_val_q    <= '0;
      squash_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      link_we_q     <= link_we_d;
      link_val_q    <= link_val_d;
      squash_cnt_q  <= squash_cnt_d;
    end
  end

  assign imem_req    = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign imem_addr   = addr_q;
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign link_we     = link_we_q;
  assign link_val    = link_val_q;
  assign squash_cnt  = squash_cnt_q;

endmodule
